// File: rtl/popcount_pkg.sv
// Shared definitions for consumers of the 8-bit popcount stage:
// sample width and maximum, window FSM states, and the saturating clamp.
package popcount_pkg;

  localparam int POPCNT_W   = 4;
  localparam int POPCNT_MAX = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // An 8-bit popcount can never exceed 8; larger codes are treated as 8.
  function automatic logic [POPCNT_W-1:0] clamp_cnt(input logic [POPCNT_W-1:0] c);
    return (c > POPCNT_W'(POPCNT_MAX)) ? POPCNT_W'(POPCNT_MAX) : c;
  endfunction

endpackage

// File: rtl/popcount_window_acc_sat_clamp.sv
// Combinational clamp of one popcount sample plus the updated running maximum.
// Reusable by any consumer of the popcount stage.
module popcount_sat_clamp
  import popcount_pkg::*;
(
  input  logic [POPCNT_W-1:0] i_count,
  input  logic [POPCNT_W-1:0] i_max,
  output logic [POPCNT_W-1:0] o_clamped,
  output logic [POPCNT_W-1:0] o_new_max
);

  logic [POPCNT_W-1:0] w_clamped;

  assign w_clamped = clamp_cnt(i_count);
  assign o_clamped = w_clamped;
  assign o_new_max = (w_clamped > i_max) ? w_clamped : i_max;

endmodule

// File: rtl/popcount_window_acc.sv
// Window accumulator of clamped popcount samples with sum/max result on a valid/ready port.
// Optional sticky over-threshold flag enabled by defining POPACC_OVER_EN.
module popcount_window_acc
  import popcount_pkg::*;
#(
  parameter  int WINDOW_LEN = 16,
  localparam int SUM_W      = $clog2(WINDOW_LEN * POPCNT_MAX + 1)
`ifdef POPACC_OVER_EN
  ,
  parameter  int OVER_THRESH = 6
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [POPCNT_W-1:0] in_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUM_W-1:0]    out_sum,
  output logic [POPCNT_W-1:0] out_max
`ifdef POPACC_OVER_EN
  ,
  output logic                out_over
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(WINDOW_LEN - 1);

  acc_state_t          r_state;
  logic [7:0]          r_cnt;
  logic [SUM_W-1:0]    r_acc;
  logic [POPCNT_W-1:0] r_max;
  logic [SUM_W-1:0]    r_out_sum;
  logic [POPCNT_W-1:0] r_out_max;
  logic                r_out_valid;

  logic [POPCNT_W-1:0] w_clamped;
  logic [POPCNT_W-1:0] w_new_max;
  logic [SUM_W-1:0]    w_sum_next;
  logic                w_accept;
  logic                w_last;

  popcount_sat_clamp u_clamp (
    .i_count   (in_count),
    .i_max     (r_max),
    .o_clamped (w_clamped),
    .o_new_max (w_new_max)
  );

  assign w_accept   = (r_state == ACCUM) && in_valid;
  assign w_last     = (r_cnt == LAST_IDX);
  assign w_sum_next = r_acc + SUM_W'(w_clamped);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_max       <= '0;
      r_out_sum   <= '0;
      r_out_max   <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (w_accept) begin
        if (w_last) begin
          r_out_sum   <= w_sum_next;
          r_out_max   <= w_new_max;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_max       <= '0;
          r_cnt       <= '0;
          r_state     <= HOLD;
        end else begin
          r_acc <= w_sum_next;
          r_max <= w_new_max;
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end else if (out_ready) begin
      // Handshake cycle never accepts a sample: one bubble per window.
      r_out_valid <= 1'b0;
      r_state     <= ACCUM;
    end
  end

`ifdef POPACC_OVER_EN
  logic r_over;
  logic r_out_over;
  logic w_over_hit;

  assign w_over_hit = int'(w_clamped) > OVER_THRESH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_over     <= 1'b0;
      r_out_over <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_out_over <= r_over | w_over_hit;
        r_over     <= 1'b0;
      end else begin
        r_over <= r_over | w_over_hit;
      end
    end
  end

  assign out_over = r_out_over;
`endif

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_max   = r_out_max;

endmodule

// File: tb/tb_popcount_window_acc.sv
// Self-checking bench for popcount_window_acc: directed table, multi-cycle corner
// sequences, WINDOW_LEN=1 instance, and randomized traffic against a queue model.
module tb_popcount_window_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_count, out_max;
  logic [7:0] out_sum;
  logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [3:0] d1_in_count, d1_out_max;
  logic [3:0] d1_out_sum;
`ifdef POPACC_OVER_EN
  logic       out_over, d1_out_over;
`endif

  popcount_window_acc #(.WINDOW_LEN(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_max(out_max)
`ifdef POPACC_OVER_EN
    , .out_over(out_over)
`endif
  );

  popcount_window_acc #(.WINDOW_LEN(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_count(d1_in_count),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_sum(d1_out_sum), .out_max(d1_out_max)
`ifdef POPACC_OVER_EN
    , .out_over(d1_out_over)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampi(input int c);
    return (c > 8) ? 8 : c;
  endfunction

  typedef struct {
    logic [63:0] s;
    int          hold;
    int          es;
    int          em;
    int          eo;
  } vec_t;

  vec_t tbl[5];

  // Feed 16 samples, then hold out_ready low for `hold` cycles with junk in_valid,
  // then complete the handshake.
  task automatic send_window(input logic [63:0] s, input int hold,
                             input int es, input int em, input int eo, input string tag);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_count = s[i*4 +: 4];
      chk({tag, " in_ready"}, int'(in_ready), 1);
      chk({tag, " out_valid_low"}, int'(out_valid), 0);
      tick();
    end
    in_valid = 1'b1;
    in_count = 4'd8;
    chk({tag, " out_valid"}, int'(out_valid), 1);
    chk({tag, " out_sum"}, int'(out_sum), es);
    chk({tag, " out_max"}, int'(out_max), em);
    chk({tag, " in_ready_hold"}, int'(in_ready), 0);
`ifdef POPACC_OVER_EN
    chk({tag, " out_over"}, int'(out_over), eo);
`else
    if (eo < 0) chk({tag, " eo"}, eo, 0);
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, " hold_valid"}, int'(out_valid), 1);
      chk({tag, " hold_sum"}, int'(out_sum), es);
      chk({tag, " hold_max"}, int'(out_max), em);
      chk({tag, " hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " release_valid"}, int'(out_valid), 0);
    chk({tag, " release_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          d1_in[3];
    int          d1_exp[3];
    logic [63:0] s;
    int          q[$];
    bit          m_hold;
    int          m_sum, m_max;
`ifdef POPACC_OVER_EN
    bit          m_over;
`endif

    rst = 1'b1;
    in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_count = '0; d1_out_ready = 1'b1;

    // Table: all 3, all 15 (clamped), ramp with hold, alternating 0/12, single 7.
    for (int i = 0; i < 16; i++) begin
      tbl[0].s[i*4 +: 4] = 4'd3;
      tbl[1].s[i*4 +: 4] = 4'd15;
      tbl[2].s[i*4 +: 4] = (i < 8) ? 4'(i) : ((i == 8) ? 4'd8 : 4'(i - 9));
      tbl[3].s[i*4 +: 4] = (i % 2 == 0) ? 4'd0 : 4'd12;
      tbl[4].s[i*4 +: 4] = (i == 5) ? 4'd7 : 4'd0;
    end
    tbl[0].hold = 0; tbl[0].es = 48;  tbl[0].em = 3; tbl[0].eo = 0;
    tbl[1].hold = 1; tbl[1].es = 128; tbl[1].em = 8; tbl[1].eo = 1;
    tbl[2].hold = 5; tbl[2].es = 57;  tbl[2].em = 8; tbl[2].eo = 1;
    tbl[3].hold = 2; tbl[3].es = 64;  tbl[3].em = 8; tbl[3].eo = 1;
    tbl[4].hold = 0; tbl[4].es = 7;   tbl[4].em = 7; tbl[4].eo = 1;

    tick(); tick();
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_sum", int'(out_sum), 0);
    chk("reset out_max", int'(out_max), 0);
    chk("reset d1_out_valid", int'(d1_out_valid), 0);
`ifdef POPACC_OVER_EN
    chk("reset out_over", int'(out_over), 0);
`endif
    rst = 1'b0;
    tick();

    for (int t = 0; t < 5; t++)
      send_window(tbl[t].s, tbl[t].hold, tbl[t].es, tbl[t].em, tbl[t].eo, $sformatf("tbl%0d", t));

    // All-6 window right after the over window: flag must clear.
    s = {16{4'd6}};
    send_window(s, 0, 96, 6, 0, "all6");

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_count = 4'd5;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    s = {16{4'd1}};
    send_window(s, 0, 16, 1, 0, "after_rst");

    // Reset during HOLD drops out_valid without a clock edge.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_count = 4'd2;
      tick();
    end
    in_valid = 1'b0;
    chk("holdrst pre_valid", int'(out_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("holdrst out_valid", int'(out_valid), 0);
    chk("holdrst out_sum", int'(out_sum), 0);
    chk("holdrst in_ready", int'(in_ready), 1);
    tick();
    rst = 1'b0;
    tick();

    // WINDOW_LEN=1: every sample is a window, followed by a bubble.
    d1_in[0] = 4; d1_in[1] = 9; d1_in[2] = 2;
    d1_exp[0] = 4; d1_exp[1] = 8; d1_exp[2] = 2;
    d1_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d1_in_valid = 1'b1;
      d1_in_count = 4'(d1_in[k]);
      chk($sformatf("w1_%0d in_ready", k), int'(d1_in_ready), 1);
      tick();
      chk($sformatf("w1_%0d out_valid", k), int'(d1_out_valid), 1);
      chk($sformatf("w1_%0d out_sum", k), int'(d1_out_sum), d1_exp[k]);
      chk($sformatf("w1_%0d out_max", k), int'(d1_out_max), d1_exp[k]);
      chk($sformatf("w1_%0d bubble", k), int'(d1_in_ready), 0);
      d1_in_count = 4'd15;
      tick();
      chk($sformatf("w1_%0d valid_fall", k), int'(d1_out_valid), 0);
      chk($sformatf("w1_%0d ready_back", k), int'(d1_in_ready), 1);
    end
    d1_in_valid = 1'b0;
    tick();
    chk("w1 idle", int'(d1_out_valid), 0);

    // Randomized traffic against a queue-based window model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    m_hold = 1'b0;
    m_sum = 0; m_max = 0;
`ifdef POPACC_OVER_EN
    m_over = 1'b0;
`endif
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_count  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) == 0);
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        q.push_back(clampi(int'(in_count)));
        if (q.size() == 16) begin
          m_sum = 0; m_max = 0;
`ifdef POPACC_OVER_EN
          m_over = 1'b0;
`endif
          foreach (q[k]) begin
            m_sum += q[k];
            if (q[k] > m_max) m_max = q[k];
`ifdef POPACC_OVER_EN
            if (q[k] > 6) m_over = 1'b1;
`endif
          end
          q.delete();
          m_hold = 1'b1;
        end
      end
      tick();
      chk("rnd out_valid", int'(out_valid), int'(m_hold));
      chk("rnd in_ready", int'(in_ready), int'(!m_hold));
      if (m_hold) begin
        chk("rnd out_sum", int'(out_sum), m_sum);
        chk("rnd out_max", int'(out_max), m_max);
`ifdef POPACC_OVER_EN
        chk("rnd out_over", int'(out_over), int'(m_over));
`endif
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
